// File: rtl/cp0_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cp0_defs : shared definitions for the CP0 register file.
//   - CP0 register numbers used by MTC0/MFC0
//   - except_type codes produced by the M-stage exception decoder
//   - Cause.ExcCode values
//   - Status/Cause bit positions and MTC0 write masks
//   - exc_code_of(): maps an except_type verdict onto the ExcCode field
// No ports (package).
// -----------------------------------------------------------------------------
package cp0_defs;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  // except_type codes from the exception decoder
  localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;

  // Cause.ExcCode values
  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  // Status bit positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int STATUS_IM_MSB  = 15;
  localparam int STATUS_BEV_BIT = 22;

  // Cause bit positions
  localparam int CAUSE_EXC_LSB  = 2;
  localparam int CAUSE_EXC_MSB  = 6;
  localparam int CAUSE_IPSW_LSB = 8;
  localparam int CAUSE_IPSW_MSB = 9;
  localparam int CAUSE_IPHW_LSB = 10;
  localparam int CAUSE_IPHW_MSB = 15;
  localparam int CAUSE_BD_BIT   = 31;

  // MTC0 write masks and hard-wired bits
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_FIXED = 32'h0040_0000;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Reset values
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  // Interrupts are recorded with ExcCode 0; every other verdict (including
  // unrecognised ones) is recorded with its own low five bits.
  function automatic logic [4:0] exc_code_of(input logic [31:0] except_type);
    logic [4:0] code;
    case (except_type)
      EXC_TYPE_INT:  code = EXCCODE_INT;
      EXC_TYPE_ADEL: code = EXCCODE_ADEL;
      EXC_TYPE_ADES: code = EXCCODE_ADES;
      EXC_TYPE_SYS:  code = EXCCODE_SYS;
      EXC_TYPE_BP:   code = EXCCODE_BP;
      EXC_TYPE_RI:   code = EXCCODE_RI;
      EXC_TYPE_OV:   code = EXCCODE_OV;
      default:       code = except_type[4:0];
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer : Count/Compare timer for CP0.
//   Count advances by one on every second clock edge (a 1-bit tick toggles
//   each edge; Count steps on edges where the tick is 1). A match of Count
//   and Compare raises timer_int one cycle later; it is held until Compare
//   is written. A Compare write always clears it, even on a match cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   count_we_i        load Count from wdata_i and clear the tick
//   compare_we_i      load Compare from wdata_i and clear timer_int
//   wdata_i [31:0]    MTC0 write data
//   count_o, compare_o [31:0]  register contents
//   timer_int_o       timer interrupt pending
// -----------------------------------------------------------------------------
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q,    tick_d;
  logic        timer_int_q, timer_int_d;

  // Next-state for Count, tick, Compare and the interrupt flag
  always_comb begin
    if (count_we_i) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else begin
      count_d = count_q + {31'd0, tick_q};
      tick_d  = ~tick_q;
    end

    if (compare_we_i) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end else begin
      compare_d   = compare_q;
      timer_int_d = timer_int_q | (count_q == compare_q);
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      tick_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      tick_q      <= tick_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile : MIPS Coprocessor-0 register file.
//   Holds Status, Cause, EPC and BadVAddr; records exception entry and ERET
//   from the M-stage exception decoder, serves MTC0 writes and combinational
//   MFC0 reads, and (optionally) runs the Count/Compare timer.
// Build option:
//   CP0_TIMER_EN  defined   -> Count/Compare/tick/timer_int via cp0_timer
//                 undefined -> Count/Compare read 0, writes ignored,
//                              timer_int_o = 0, Cause.IP7 = ext_int[5]
// Parameters:
//   PRID_VAL      value returned for PRId (register 15)
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   we_i, waddr_i, wdata_i      MTC0 write
//   raddr_i, rdata_o            MFC0 read (combinational)
//   ext_int [5:0]               hardware interrupt lines
//   is_except, except_type      exception / ERET commit and its kind
//   current_pc, is_in_delayslot faulting PC and delay-slot flag
//   bad_addr                    faulting address for AdEL/AdES
//   status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o  contents
//   timer_int_o                 timer interrupt pending
// -----------------------------------------------------------------------------
module cp0_regfile
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  ext_int,
  input  logic        is_except,
  input  logic [31:0] except_type,
  input  logic [31:0] current_pc,
  input  logic        is_in_delayslot,
  input  logic [31:0] bad_addr,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] status_q,   status_d;
  logic [31:0] cause_q,    cause_d;
  logic [31:0] epc_q,      epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        exc_entry_s;
  logic        eret_s;
  logic        exl_s;
  logic        addr_exc_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        wr_epc_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        timer_int_s;
  logic        ip7_s;

  assign exc_entry_s = is_except && (except_type != EXC_TYPE_ERET);
  assign eret_s      = is_except && (except_type == EXC_TYPE_ERET);
  assign exl_s       = status_q[STATUS_EXL_BIT];
  assign addr_exc_s  = (except_type == EXC_TYPE_ADEL) || (except_type == EXC_TYPE_ADES);
  assign wr_status_s = we_i && (waddr_i == REG_STATUS);
  assign wr_cause_s  = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc_s    = we_i && (waddr_i == REG_EPC);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_i && (waddr_i == REG_COUNT)),
    .compare_we_i (we_i && (waddr_i == REG_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count_s),
    .compare_o    (compare_s),
    .timer_int_o  (timer_int_s)
  );
  assign ip7_s = ext_int[5] | timer_int_s;
`else
  assign count_s     = 32'd0;
  assign compare_s   = 32'd0;
  assign timer_int_s = 1'b0;
  assign ip7_s       = ext_int[5];
`endif

  // Next-state for Status/Cause/EPC/BadVAddr; an exception or ERET takes
  // priority over an MTC0 to the same register.
  always_comb begin
    // Status: entry sets EXL, ERET clears it, otherwise MTC0 with mask
    if (exc_entry_s) begin
      status_d                 = status_q;
      status_d[STATUS_EXL_BIT] = 1'b1;
    end else if (eret_s) begin
      status_d                 = status_q;
      status_d[STATUS_EXL_BIT] = 1'b0;
    end else if (wr_status_s) begin
      status_d = (wdata_i & STATUS_WMASK) | STATUS_FIXED;
    end else begin
      status_d = status_q;
    end

    // Cause: ExcCode always recorded on entry; BD only for the first
    // (non-nested) exception.
    if (exc_entry_s) begin
      cause_d                              = cause_q;
      cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code_of(except_type);
      if (!exl_s) begin
        cause_d[CAUSE_BD_BIT] = is_in_delayslot;
      end else begin
        cause_d[CAUSE_BD_BIT] = cause_q[CAUSE_BD_BIT];
      end
    end else if (wr_cause_s) begin
      cause_d = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
    end else begin
      cause_d = cause_q;
    end
    // Hardware interrupt pending bits are sampled every cycle
    cause_d[CAUSE_IPHW_MSB:CAUSE_IPHW_LSB] = {ip7_s, ext_int[4:0]};

    // EPC: a nested exception leaves EPC alone, so MTC0 may still land
    if (exc_entry_s && !exl_s) begin
      epc_d = is_in_delayslot ? (current_pc - 32'd4) : current_pc;
    end else if (wr_epc_s) begin
      epc_d = wdata_i;
    end else begin
      epc_d = epc_q;
    end

    // BadVAddr: written only by address-error exceptions
    if (exc_entry_s && addr_exc_s) begin
      badvaddr_d = bad_addr;
    end else begin
      badvaddr_d = badvaddr_q;
    end
  end

  // CP0 state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // MFC0 read mux
  always_comb begin
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_s;
      REG_COMPARE:  rdata_o = compare_s;
      REG_STATUS:   rdata_o = status_q;
      REG_CAUSE:    rdata_o = cause_q;
      REG_EPC:      rdata_o = epc_q;
      REG_PRID:     rdata_o = PRID_VAL;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign count_o     = count_s;
  assign compare_o   = compare_s;
  assign timer_int_o = timer_int_s;

endmodule

// File: tb/tb_cp0_regfile.sv
// -----------------------------------------------------------------------------
// tb_cp0_regfile : self-checking bench for cp0_regfile.
// A field-level reference model (Count derived from cycles since last load)
// is compared against every DUT output after each rising edge; directed
// sequences additionally pin literal values.
// -----------------------------------------------------------------------------
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  ext_int;
  logic        is_except;
  logic [31:0] except_type;
  logic [31:0] current_pc;
  logic        is_in_delayslot;
  logic [31:0] bad_addr;
  logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  cp0_regfile #(.PRID_VAL(32'h0000_4220)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .ext_int(ext_int),
    .is_except(is_except), .except_type(except_type), .current_pc(current_pc),
    .is_in_delayslot(is_in_delayslot), .bad_addr(bad_addr),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .badvaddr_o(badvaddr_o), .count_o(count_o), .compare_o(compare_o),
    .timer_int_o(timer_int_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (field level) ----------------
  logic [7:0]  m_im;
  logic        m_exl, m_ie;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic [5:0]  m_iph;
  logic [1:0]  m_ips;
  logic [31:0] m_epc, m_bad, m_base, m_cmp;
  logic        m_tint;
  longint      m_cyc;
  logic [31:0] t_cnt;
  logic        t_tint_old, t_exl_old, t_entry, t_eret;

  function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_EN
    return m_base + 32'(m_cyc >> 1);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] m_status();
    return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, 15'd0, m_iph, m_ips, 1'b0, m_exc, 2'd0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_exc = 5'd0;
      m_iph = 6'd0; m_ips = 2'd0; m_epc = 32'd0; m_bad = 32'd0;
      m_base = 32'd0; m_cmp = 32'd0; m_tint = 1'b0; m_cyc = 0;
    end else begin
      t_cnt      = m_count();
      t_tint_old = m_tint;
      t_exl_old  = m_exl;
      t_entry    = is_except && (except_type != 32'h0000_000e);
      t_eret     = is_except && (except_type == 32'h0000_000e);
`ifdef CP0_TIMER_EN
      if (we_i && waddr_i == 5'd11) begin
        m_cmp = wdata_i; m_tint = 1'b0;
      end else if (t_cnt == m_cmp) begin
        m_tint = 1'b1;
      end
      if (we_i && waddr_i == 5'd9) begin
        m_base = wdata_i; m_cyc = 0;
      end else begin
        m_cyc = m_cyc + 1;
      end
`endif
      m_iph = {ext_int[5] | t_tint_old, ext_int[4:0]};
      if (t_entry) begin
        m_exl = 1'b1;
        m_exc = (except_type == 32'h1) ? 5'd0 : except_type[4:0];
        if (!t_exl_old) begin
          m_bd  = is_in_delayslot;
          m_epc = is_in_delayslot ? current_pc - 32'd4 : current_pc;
        end else if (we_i && waddr_i == 5'd14) begin
          m_epc = wdata_i;
        end
        if (except_type == 32'h4 || except_type == 32'h5) m_bad = bad_addr;
      end else begin
        if (t_eret) m_exl = 1'b0;
        else if (we_i && waddr_i == 5'd12) begin
          m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0];
        end
        if (we_i && waddr_i == 5'd13) m_ips = wdata_i[9:8];
        if (we_i && waddr_i == 5'd14) m_epc = wdata_i;
      end
    end
  end

  // Compare process: every output against the model after each edge
  always @(posedge clk) begin
    #2;
    if (chk_en && !rst) begin
      chk("status", status_o, m_status());
      chk("cause", cause_o, m_cause());
      chk("epc", epc_o, m_epc);
      chk("badvaddr", badvaddr_o, m_bad);
      chk("count", count_o, m_count());
      chk("compare", compare_o, m_cmp);
      chk("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
      chk("rdata", rdata_o, m_read(raddr_i));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    we_i = 1'b0; is_except = 1'b0; except_type = 32'd0;
    ext_int = 6'd0; is_in_delayslot = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); idle(); we_i = 1'b1; waddr_i = a; wdata_i = d;
    @(posedge clk); #2;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] ba);
    @(negedge clk); idle(); is_except = 1'b1; except_type = t;
    current_pc = pc; is_in_delayslot = ds; bad_addr = ba;
    @(posedge clk); #2;
  endtask

  logic [31:0] sel_type [12];
  int n;

  initial begin
    rst = 1'b1; idle(); waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0;
    current_pc = 32'd0; bad_addr = 32'd0;
    sel_type = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he,
                 32'he, 32'h3, 32'h1f, 32'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset with Status already written
    mtc0(5'd12, 32'hFFFF_FFFF);
    @(negedge clk); idle(); #3 rst = 1'b1; #1;
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_count", count_o, 32'd0);
    chk("rst_timer", {31'd0, timer_int_o}, 32'd0);
    chk("rst_cause", cause_o, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Status write mask
    mtc0(5'd12, 32'hFFFF_FFFF);
    @(negedge clk); idle(); raddr_i = 5'd12;
    @(posedge clk); #2;
    chk("mfc0_status", rdata_o, 32'h0040_FF03);
    raddr_i = 5'd15; #1;
    chk("mfc0_prid", rdata_o, 32'h0000_4220);
    mtc0(5'd12, 32'd0);

    // Syscall then ERET
    exc(32'h8, 32'hBFC0_1000, 1'b0, 32'd0);
    chk("sys_epc", epc_o, 32'hBFC0_1000);
    chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
    chk("sys_bd", {31'd0, cause_o[31]}, 32'd0);
    exc(32'he, 32'h0000_0040, 1'b0, 32'd0);
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
    chk("eret_epc", epc_o, 32'hBFC0_1000);

    // AdEL in delay slot, then nested exception
    exc(32'h4, 32'hBFC0_2004, 1'b1, 32'h8000_0003);
    chk("adel_epc", epc_o, 32'hBFC0_2000);
    chk("adel_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("adel_bad", badvaddr_o, 32'h8000_0003);
    chk("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
    exc(32'hc, 32'h0000_0500, 1'b0, 32'd0);
    chk("nested_epc", epc_o, 32'hBFC0_2000);
    chk("nested_exccode", {27'd0, cause_o[6:2]}, 32'hc);
    exc(32'he, 32'd0, 1'b0, 32'd0);

    // Timer: Count=0 then Compare=5
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); idle();
      @(posedge clk); #2; n++;
      if (timer_int_o) break;
    end
`ifdef CP0_TIMER_EN
    chk("timer_rise_cycle", n, 32'd11);
    @(negedge clk); idle(); @(posedge clk); #2;
    chk("timer_cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'h0000_FFFF);
    chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
`else
    chk("timer_off", {31'd0, timer_int_o}, 32'd0);
    chk("timer_off_ip7", {31'd0, cause_o[15]}, 32'd0);
`endif

    // Same-cycle MTC0 EPC and exception
    @(negedge clk); idle(); we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h1234;
    is_except = 1'b1; except_type = 32'h8; current_pc = 32'h100;
    @(posedge clk); #2;
    chk("same_cycle_epc", epc_o, 32'h100);
    exc(32'he, 32'd0, 1'b0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      we_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: waddr_i = 5'd8;
        1: waddr_i = 5'd9;
        2: waddr_i = 5'd11;
        3: waddr_i = 5'd12;
        4: waddr_i = 5'd13;
        5: waddr_i = 5'd14;
        6: waddr_i = 5'd15;
        default: waddr_i = 5'($urandom_range(0, 31));
      endcase
      wdata_i = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15));
      raddr_i = 5'($urandom_range(0, 31));
      ext_int = 6'($urandom_range(0, 63));
      is_except = ($urandom_range(0, 5) == 0);
      except_type = sel_type[$urandom_range(0, 11)];
      if (except_type == 32'h0 && $urandom_range(0, 1) == 1) except_type = $urandom;
      current_pc = $urandom;
      is_in_delayslot = 1'($urandom_range(0, 1));
      bad_addr = $urandom;
      if (i == 1500) begin
        #3 rst = 1'b1; #1;
        chk("midrst_status", status_o, 32'h0040_0000);
        chk("midrst_cause", cause_o, 32'd0);
        chk("midrst_count", count_o, 32'd0);
        chk("midrst_timer", {31'd0, timer_int_o}, 32'd0);
        @(negedge clk); rst = 1'b0;
      end
    end

    @(negedge clk); idle();
    @(posedge clk); #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS pipeline. It sits directly downstream of the memory-stage exception decoder and consumes that decoder's `is_except`/`except_type` verdict together with the faulting PC, delay-slot flag and bad address. It updates Status/Cause/EPC/BadVAddr on exception entry and ERET, and serves MTC0/MFC0. It also runs the Count/Compare timer. It feeds Status, Cause and EPC back to the decoder every cycle.

## Interface
Parameters:
- `PRID_VAL`, 32'h0000_4220: constant returned for PRId reads (reg 15).

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `we_i`  in  1  MTC0 write enable (M stage)
- `waddr_i`  in  5  MTC0 destination register number
- `wdata_i`  in  32  MTC0 data
- `raddr_i`  in  5  MFC0 source register number
- `rdata_o`  out  32  MFC0 read data, combinational from `raddr_i`
- `ext_int`  in  6  hardware interrupt lines
- `is_except`  in  1  exception/ERET commit this cycle
- `except_type`  in  32  1=Int, 4=AdEL, 5=AdES, 8=Sys, 9=Bp, 0xa=RI, 0xc=Ov, 0xe=ERET
- `current_pc`  in  32  PC of the M-stage instruction
- `is_in_delayslot`  in  1  M-stage instruction is in a branch delay slot
- `bad_addr`  in  32  faulting virtual address for AdEL/AdES
- `status_o`, `cause_o`, `epc_o`, `badvaddr_o`, `count_o`, `compare_o`  out  32 each  register contents
- `timer_int_o`  out  1  timer interrupt pending

## Operation
- Register map: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15. Other addresses read 0, and writes to them are ignored.
- Status write mask: IM[15:8], EXL[1], IE[0]. BEV[22] is hard-wired 1. All other bits read 0.
- Cause write mask: IP[9:8] only.
- BadVAddr is read-only to MTC0.
- EPC, Count and Compare are fully writable.
- Every cycle, Cause.IP[15:10] <= {ext_int[5] | timer_int, ext_int[4:0]}.
- Exception entry (`is_except` and `except_type`≠0xe):
  - If Status.EXL=0: EPC <= delayslot ? `current_pc`−4 : `current_pc`, and Cause.BD[31] <= `is_in_delayslot`.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= 0 for type 1; otherwise `except_type[4:0]`.
  - For AdEL/AdES: BadVAddr <= `bad_addr`.
- ERET (`is_except`, type 0xe): Status.EXL <= 0. Nothing else changes.
- Simultaneous MTC0 and `is_except`: the exception update wins on every register it touches. The MTC0 still applies to registers the exception does not touch.
- Unknown `except_type` with `is_except`: handled as entry with ExcCode = `except_type[4:0]`.

## Timing
- Reset values: Status=0x0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, `timer_int_o`=0, internal tick=0.
- `rdata_o` is combinational from registered state. There is no write-through: an MTC0 becomes visible the cycle after it is written.
- Exception and MTC0 updates are visible on `*_o` the cycle after the commit edge.
- Count increments by 1 on every second `clk` edge, driven by a 1-bit tick toggle. It wraps 0xFFFF_FFFF→0.
- An MTC0 to Count loads `wdata_i` and clears tick.
- `timer_int_o` is set one cycle after Count==Compare. It holds until Compare is written.
- An MTC0 to Compare clears `timer_int_o`. If the clear coincides with a match, the clear wins.
- An asynchronous `rst` mid-operation forces all reset values immediately, including tick.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare registers, tick and `timer_int_o` are implemented as described above.
- `CP0_TIMER_EN` undefined:
  - Count and Compare read 0, and writes to them are ignored.
  - `timer_int_o` is tied to 0.
  - IP7 reflects `ext_int[5]` only.

## Structure
- Package `cp0_defs`:
  - register numbers
  - `except_type` codes
  - ExcCode values
  - Status/Cause bit positions (IE, EXL, IM, BEV, IP, ExcCode, BD)
  - write masks
- Sub-module `cp0_timer`: holds Count, Compare, tick and `timer_int`. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset with Status already written, then release: Status=0x0040_0000, EPC=0, Count=0, `timer_int_o`=0.
- MTC0 Status=0xFFFF_FFFF, then MFC0 12: reads 0x0040_FF03.
- `is_except`, type 8, pc=0xBFC0_1000, not delay slot: next cycle EPC=0xBFC0_1000, ExcCode=8, EXL=1, BD=0. Then type 0xe: EXL=0, EPC unchanged.
- Type 4, delay slot, pc=0xBFC0_2004, bad_addr=0x8000_0003: EPC=0xBFC0_2000, BD=1, BadVAddr=0x8000_0003, ExcCode=4. A second exception while EXL=1 leaves EPC unchanged.
- Compare=5, Count=0: `timer_int_o` rises about 11 cycles later, and Cause[15]=1. MTC0 Compare clears it. With the macro off, it stays 0.
- Same-cycle MTC0 EPC=0x1234 and exception at pc=0x100: EPC=0x100.
